field_msg_assembler: RTL



---
 rtl/field_msg_assembler_pkg.sv | 40 ++++
 rtl/field_msg_assembler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/field_msg_assembler_pkg.sv
// ---------------------------------------------------------------------------
// fast_field_pkg
// Shared widths, the decoded-field entry layout, and the assembler state
// encoding for the FAST field-to-message path.
//   BEAT_WIDTH        width of one decoded field (beat)
//   MAX_MESSAGE_SIZE  maximum number of fields per message
//   IW                field index width
//   MSG_ID_SIZE       message ID width
//   CNT_WIDTH         statistics counter width
//   ENTRY_WIDTH       width of one packed FIFO entry
//   MSG_WIDTH         width of the flattened beat bus
// ---------------------------------------------------------------------------
package fast_field_pkg;

  localparam int BEAT_WIDTH       = 64;
  localparam int MAX_MESSAGE_SIZE = 10;
  localparam int IW               = $clog2(MAX_MESSAGE_SIZE);
  localparam int MSG_ID_SIZE      = 21;
  localparam int CNT_WIDTH        = 32;
  localparam int ENTRY_WIDTH      = MSG_ID_SIZE + IW + BEAT_WIDTH;
  localparam int MSG_WIDTH        = MAX_MESSAGE_SIZE * BEAT_WIDTH;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] msg_id;
    logic [IW-1:0]          idx;
    logic [BEAT_WIDTH-1:0]  data;
  } field_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } asm_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/field_msg_assembler.sv
// ---------------------------------------------------------------------------
// field_msg_assembler
// Pops decoded fields from the field FIFO and gathers all consecutive fields
// sharing one message ID into a wide record, which is then offered
// downstream with a presence mask and an error flag.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   fld_valid/fld_ready  field FIFO handshake
//   fld_msg_id, fld_idx,
//   fld_data, fld_last   field entry contents
//   msg_valid/msg_ready  assembled message handshake
//   msg_id, msg_beats,
//   msg_mask, msg_err    assembled message record (beat k at k*BEAT_WIDTH)
//   stat_msgs            messages delivered (wraps)
//   stat_errs            errored messages delivered (saturates)
// ---------------------------------------------------------------------------
module field_msg_assembler
  import fast_field_pkg::*;
(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        fld_valid,
  output logic                        fld_ready,
  input  logic [MSG_ID_SIZE-1:0]      fld_msg_id,
  input  logic [IW-1:0]               fld_idx,
  input  logic [BEAT_WIDTH-1:0]       fld_data,
  input  logic                        fld_last,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic [MSG_ID_SIZE-1:0]      msg_id,
  output logic [MSG_WIDTH-1:0]        msg_beats,
  output logic [MAX_MESSAGE_SIZE-1:0] msg_mask,
  output logic                        msg_err,
  output logic [CNT_WIDTH-1:0]        stat_msgs,
  output logic [CNT_WIDTH-1:0]        stat_errs
);

  field_entry_t entry;

  asm_state_t                  state_q, state_d;
  logic [MSG_ID_SIZE-1:0]      cur_id_q, cur_id_d;
  logic [BEAT_WIDTH-1:0]       beats_q [MAX_MESSAGE_SIZE];
  logic [BEAT_WIDTH-1:0]       beats_d [MAX_MESSAGE_SIZE];
  logic [MAX_MESSAGE_SIZE-1:0] mask_q, mask_d;
  logic                        err_q, err_d;
  logic                        msg_valid_q, msg_valid_d;
  logic [CNT_WIDTH-1:0]        stat_msgs_q, stat_msgs_d;
  logic [CNT_WIDTH-1:0]        stat_errs_q, stat_errs_d;

  logic [MAX_MESSAGE_SIZE-1:0] idx_hit;
  logic                        idx_oor;
  logic                        idx_dup;
  logic                        id_match;
  logic                        accept;

  assign entry = '{msg_id: fld_msg_id, idx: fld_idx, data: fld_data};

  // One-hot decode of the field index; an index past the last beat decodes
  // to all zeros, which is how out-of-range entries are recognised.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_MESSAGE_SIZE; gi++) begin : g_beat
      assign idx_hit[gi] = (entry.idx == IW'(gi));
      assign msg_beats[gi*BEAT_WIDTH +: BEAT_WIDTH] = beats_q[gi];
    end
  endgenerate

  assign idx_oor  = ~|idx_hit;
  assign idx_dup  = |(idx_hit & mask_q);
  assign id_match = (entry.msg_id == cur_id_q);

  // A different ID while collecting is left in the FIFO: it belongs to the
  // next message, and the current one is closed as truncated.
  always_comb begin
    fld_ready = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE:    fld_ready = 1'b1;
        COLLECT: fld_ready = !(fld_valid && !id_match);
        default: fld_ready = 1'b0;
      endcase
    end
  end

  assign accept = fld_valid && fld_ready;

  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    beats_d     = beats_q;
    mask_d      = mask_q;
    err_d       = err_q;
    stat_msgs_d = stat_msgs_q;
    stat_errs_d = stat_errs_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && fld_valid && !id_match) begin
          err_d   = 1'b1;
          state_d = EMIT;
        end else if (accept) begin
          if (state_q == IDLE) begin
            cur_id_d = entry.msg_id;
          end
          // Only the first write to a beat lands; repeats and out-of-range
          // indices are swallowed and flagged.
          for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
            if (idx_hit[k] && !mask_q[k]) begin
              beats_d[k] = entry.data;
            end
          end
          mask_d = mask_q | idx_hit;
          if (idx_oor || idx_dup) begin
            err_d = 1'b1;
          end
          state_d = fld_last ? EMIT : COLLECT;
        end
      end
      EMIT: begin
        if (msg_ready) begin
          for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
            beats_d[k] = '0;
          end
          mask_d      = '0;
          err_d       = 1'b0;
          state_d     = IDLE;
          stat_msgs_d = stat_msgs_q + 1'b1;
          if (err_q) begin
            stat_errs_d = sat_inc(stat_errs_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    msg_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cur_id_q    <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
      msg_valid_q <= 1'b0;
      stat_msgs_q <= '0;
      stat_errs_q <= '0;
      for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
        beats_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      msg_valid_q <= msg_valid_d;
      stat_msgs_q <= stat_msgs_d;
      stat_errs_q <= stat_errs_d;
      for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
        beats_q[k] <= beats_d[k];
      end
    end
  end

  assign msg_valid = msg_valid_q;
  assign msg_id    = cur_id_q;
  assign msg_mask  = mask_q;
  assign msg_err   = err_q;
  assign stat_msgs = stat_msgs_q;
  assign stat_errs = stat_errs_q;

endmodule
